// File: rtl/inst_fetch_bridge.sv
// One-entry instruction buffer that fetches a missed word over a simple req/ack bus.
// A hit returns data the same cycle; a miss stalls the cpu until ack+1. A silent bus times out to a NOP.
module inst_fetch_bridge #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rom_ce_i,
   input  logic [31:0] rom_addr_i,
   input  logic        flush_i,
   output logic [31:0] rom_data_o,
   output logic        stall_req_o,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        fetch_err_o,
   output logic [15:0] fetch_cnt_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE, REQ} state_t;

   state_t        state, state_nxt;
   logic          buf_vld;
   logic [29:0]   buf_addr;
   logic [31:0]   buf_dat;
   logic [TW-1:0] tmo_cnt;
   logic          flush_pend;
   logic          hit;
   logic          start;
   logic          ack_acc;
   logic          tmo_hit;
   logic          discard;
   logic          unused_addr_lsb;

   assign hit             = buf_vld && (buf_addr == rom_addr_i[31:2]);
   assign discard         = flush_i || flush_pend;
   assign unused_addr_lsb = ^rom_addr_i[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      rom_data_o  = '0;
      stall_req_o = 1'b0;
      start       = 1'b0;
      ack_acc     = 1'b0;
      tmo_hit     = 1'b0;
      if (state == IDLE) begin
         if (rom_ce_i) begin
            if (hit) begin
               rom_data_o = buf_dat;
            end else begin
               stall_req_o = 1'b1;
               start       = 1'b1;
               state_nxt   = REQ;
            end
         end
      end else begin
         stall_req_o = rom_ce_i;
         // Ack is checked first so it beats a timeout landing in the same cycle.
         if (bus_ack_i) begin
            ack_acc   = 1'b1;
            state_nxt = IDLE;
         end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_hit   = 1'b1;
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_req_o   <= 1'b0;
         bus_addr_o  <= '0;
         buf_vld     <= 1'b0;
         buf_addr    <= '0;
         buf_dat     <= '0;
         tmo_cnt     <= '0;
         flush_pend  <= 1'b0;
         fetch_err_o <= 1'b0;
         fetch_cnt_o <= '0;
      end else begin
         fetch_err_o <= 1'b0;
         if (start) begin
            bus_req_o  <= 1'b1;
            bus_addr_o <= {rom_addr_i[31:2], 2'b00};
            tmo_cnt    <= '0;
            flush_pend <= 1'b0;
         end else if (state == REQ) begin
            if (!ack_acc && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
            if (flush_i)              flush_pend <= 1'b1;
         end

         if (ack_acc || tmo_hit) begin
            bus_req_o <= 1'b0;
            // A flush seen at any point during the fetch throws the result away.
            if (discard) begin
               buf_vld <= 1'b0;
            end else begin
               buf_vld     <= 1'b1;
               buf_addr    <= bus_addr_o[31:2];
               buf_dat     <= ack_acc ? bus_rdata_i : 32'h0;
               fetch_err_o <= tmo_hit;
            end
         end else if (flush_i) begin
            buf_vld <= 1'b0;
         end

         if (ack_acc && (fetch_cnt_o != 16'hFFFF)) fetch_cnt_o <= fetch_cnt_o + 16'd1;
      end
   end

endmodule
